sn74xx251_scan_ctrl: RTL

SN74XX251_SCAN_CTRL -- requirements
Module: sn74xx251_scan_ctrl

---
 rtl/sn74xx251_scan_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/sn74xx251_scan_ctrl.sv
`default_nettype none
// ==========================================================================
// sn74xx251_scan_ctrl : scans enabled channels of an external '251 8:1 mux
// into an 8-bit result. Define SN74_SCAN_CHECK_EN to check the complement output.
// Rev 1.0 : initial release
// ==========================================================================
module sn74xx251_scan_ctrl #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] mask,
  output logic [2:0] sel,
  output logic       strobe,
  input  logic       mux_out,
  input  logic       mux_nout,
  output logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ENABLE = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [3:0] c_settle_last = 4'(SETTLE - 1);

  state_t     r_state;
  logic [7:0] r_pend;
  logic [2:0] r_ch;
  logic [3:0] r_cnt;
  logic [7:0] r_shadow;
  logic [2:0] r_sel;
  logic       r_strobe;
  logic [7:0] r_data;
  logic       r_busy;
  logic       r_done;

  logic [7:0] w_pend_rem;
  logic [7:0] w_shadow_upd;
  logic [2:0] w_next_ch;

  function automatic logic [2:0] f_lowest(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Channels still to visit after the current one; shadow bit is known clear here.
  assign w_pend_rem   = r_pend & ~(8'd1 << r_ch);
  assign w_shadow_upd = r_shadow | ({7'd0, mux_out} << r_ch);
  assign w_next_ch    = f_lowest(w_pend_rem);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_pend   <= 8'd0;
      r_ch     <= 3'd0;
      r_cnt    <= 4'd0;
      r_shadow <= 8'd0;
      r_sel    <= 3'd0;
      r_strobe <= 1'b1;
      r_data   <= 8'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_sel    <= 3'd0;
          r_strobe <= 1'b1;
          r_busy   <= 1'b0;
          if (start) begin
            r_shadow <= 8'd0;
            if (mask != 8'd0) begin
              r_pend  <= mask;
              r_ch    <= f_lowest(mask);
              r_sel   <= f_lowest(mask);
              r_busy  <= 1'b1;
              r_state <= S_SETUP;
            end else begin
              r_data  <= 8'd0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_SETUP: begin
          r_strobe <= 1'b0;
          r_cnt    <= 4'd0;
          r_state  <= S_ENABLE;
        end
        S_ENABLE: begin
          if (r_cnt == c_settle_last) begin
            r_cnt   <= 4'd0;
            r_state <= S_SAMPLE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_SAMPLE: begin
          // Output-disable goes up together with any sel change (break-before-make).
          r_shadow <= w_shadow_upd;
          r_pend   <= w_pend_rem;
          r_strobe <= 1'b1;
          if (w_pend_rem != 8'd0) begin
            r_ch    <= w_next_ch;
            r_sel   <= w_next_ch;
            r_state <= S_SETUP;
          end else begin
            r_sel   <= 3'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_data  <= w_shadow_upd;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef SN74_SCAN_CHECK_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_err <= 1'b0;
    end else if (r_state == S_SAMPLE && (mux_nout == mux_out)) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  logic w_unused_nout;
  assign w_unused_nout = mux_nout;
  assign err           = 1'b0;
`endif

  assign sel    = r_sel;
  assign strobe = r_strobe;
  assign data   = r_data;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule
`default_nettype wire
